// File: rtl/dot_operand_streamer_pkg.sv
// Shared definitions for the dot-product operand path.
// Used by the streamer and by the dot-product control block.
package dot_operand_streamer_pkg;

    localparam int unsigned ELEMENT_WIDTH = 32;
    localparam int unsigned NO_OF_UNITS   = 8;
    localparam int unsigned ADDR_WIDTH    = 16;
    localparam int unsigned CHUNK_WIDTH   = ELEMENT_WIDTH * NO_OF_UNITS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_DONE
    } state_e;

    function automatic logic [31:0] chunk_count(
        input logic [31:0] total,
        input int unsigned n
    );
        return (total / n) + {31'd0, (total % n) != 32'd0};
    endfunction

endpackage

// File: rtl/dot_operand_streamer_fifo.sv
// Two-entry chunk FIFO with a registered head and occupancy output.
// The head register drives the consumer directly.
module two_entry_chunk_fifo #(
    parameter int unsigned width = 512
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [width-1:0] din_i,
    input  logic             pop_i,
    output logic [width-1:0] head_o,
    output logic             valid_o,
    output logic [1:0]       occ_o
);

    logic [width-1:0] head_q, head_d;
    logic [width-1:0] tail_q, tail_d;
    logic [1:0]       cnt_q, cnt_d;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        unique case ({push_i, pop_i})
            2'b10: begin
                if (cnt_q == 2'd0) head_d = din_i;
                else               tail_d = din_i;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                // Simultaneous push and pop keeps the count unchanged.
                if (cnt_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = din_i;
                end else begin
                    head_d = din_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head_o  = head_q;
    assign valid_o = (cnt_q != 2'd0);
    assign occ_o   = cnt_q;

endmodule

// File: rtl/dot_operand_streamer.sv
// Streams two chunked vectors from memory to the dot-product block,
// zero-padding the final partial chunk.
module dot_operand_streamer
    import dot_operand_streamer_pkg::*;
#(
    parameter int unsigned element_width = ELEMENT_WIDTH,
    parameter int unsigned no_of_units   = NO_OF_UNITS,
    parameter int unsigned addr_width    = ADDR_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [31:0]                          total,
    input  logic [addr_width-1:0]                base_a,
    input  logic [addr_width-1:0]                base_b,
    output logic                                 mem_a_rd_en,
    output logic                                 mem_b_rd_en,
    output logic [addr_width-1:0]                mem_a_addr,
    output logic [addr_width-1:0]                mem_b_addr,
    input  logic [element_width*no_of_units-1:0] mem_a_rdata,
    input  logic [element_width*no_of_units-1:0] mem_b_rdata,
    output logic [element_width*no_of_units-1:0] first_row_plus_additional,
    output logic [element_width*no_of_units-1:0] vector2,
    output logic                                 outsider_read_now,
    input  logic                                 consumer_ready,
    output logic                                 busy,
    output logic                                 done
);

    localparam int unsigned CW = element_width * no_of_units;

    state_e                state_q, state_d;
    logic [31:0]           chunks_q, chunks_d;
    logic [31:0]           rem_q, rem_d;
    logic [31:0]           rd_cnt_q, rd_cnt_d;
    logic [31:0]           acc_cnt_q, acc_cnt_d;
    logic [addr_width-1:0] base_a_q, base_a_d;
    logic [addr_width-1:0] base_b_q, base_b_d;
    logic                  inflight_q, inflight_last_q;

    logic                  rd_en, pop, last_rd, last_acc;
    logic [2:0]            credit;
    logic [1:0]            occ;
    logic                  fifo_valid;
    logic [CW-1:0]         pad_a, pad_b;
    logic [2*CW-1:0]       fifo_head;

    // Credit counts the slot freed by a pop in this same cycle.
    assign pop      = fifo_valid & consumer_ready;
    assign credit   = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};
    assign rd_en    = (state_q == ST_FETCH) && (credit < 3'd2);
    assign last_rd  = (rd_cnt_q == chunks_q - 32'd1);
    assign last_acc = (acc_cnt_q == chunks_q - 32'd1);

    always_comb begin
        state_d   = state_q;
        chunks_d  = chunks_q;
        rem_d     = rem_q;
        rd_cnt_d  = rd_cnt_q;
        acc_cnt_d = acc_cnt_q;
        base_a_d  = base_a_q;
        base_b_d  = base_b_q;
        if (pop) acc_cnt_d = acc_cnt_q + 32'd1;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    chunks_d  = chunk_count(total, no_of_units);
                    rem_d     = total % no_of_units;
                    rd_cnt_d  = 32'd0;
                    acc_cnt_d = 32'd0;
                    base_a_d  = base_a;
                    base_b_d  = base_b;
                    state_d   = (total == 32'd0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (rd_en) begin
                    rd_cnt_d = rd_cnt_q + 32'd1;
                    if (last_rd) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && last_acc) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            chunks_q        <= 32'd0;
            rem_q           <= 32'd0;
            rd_cnt_q        <= 32'd0;
            acc_cnt_q       <= 32'd0;
            base_a_q        <= '0;
            base_b_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            chunks_q        <= chunks_d;
            rem_q           <= rem_d;
            rd_cnt_q        <= rd_cnt_d;
            acc_cnt_q       <= acc_cnt_d;
            base_a_q        <= base_a_d;
            base_b_q        <= base_b_d;
            inflight_q      <= rd_en;
            inflight_last_q <= rd_en & last_rd;
        end
    end

    always_comb begin
        pad_a = mem_a_rdata;
        pad_b = mem_b_rdata;
        for (int i = 0; i < int'(no_of_units); i++) begin
            if (inflight_last_q && rem_q != 32'd0 && 32'(i) >= rem_q) begin
                pad_a[i*element_width +: element_width] = '0;
                pad_b[i*element_width +: element_width] = '0;
            end
        end
    end

    two_entry_chunk_fifo #(
        .width(2 * CW)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push_i (inflight_q),
        .din_i  ({pad_a, pad_b}),
        .pop_i  (pop),
        .head_o (fifo_head),
        .valid_o(fifo_valid),
        .occ_o  (occ)
    );

    assign mem_a_rd_en               = rd_en;
    assign mem_b_rd_en               = rd_en;
    assign mem_a_addr                = base_a_q + rd_cnt_q[addr_width-1:0];
    assign mem_b_addr                = base_b_q + rd_cnt_q[addr_width-1:0];
    assign first_row_plus_additional = fifo_head[2*CW-1:CW];
    assign vector2                   = fifo_head[CW-1:0];
    assign outsider_read_now         = fifo_valid;
    assign busy = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_dot_operand_streamer.sv
// Self-checking bench for dot_operand_streamer: vector table,
// random runs and a mid-stream reset, checked against a lane model.
module tb_dot_operand_streamer;
    import dot_operand_streamer_pkg::*;

    localparam int EW = 32;
    localparam int N  = 8;
    localparam int AW = 16;
    localparam int CW = EW * N;

    typedef struct {
        int          total;
        logic [15:0] ba;
        logic [15:0] bb;
        int          mode;
        int          poke;
        int          exp_chunks;
        int          exp_first;
        int          exp_done;
    } vec_t;

    logic          clk, reset, start, consumer_ready;
    logic [31:0]   total;
    logic [AW-1:0] base_a, base_b, mem_a_addr, mem_b_addr;
    logic          mem_a_rd_en, mem_b_rd_en;
    logic [CW-1:0] mem_a_rdata, mem_b_rdata, first_row, vector2;
    logic          valid, busy, done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int          cur_total;
    logic [15:0] cur_ba, cur_bb;
    int run_id = 0, seen_id = 0;
    int xf_idx = 0, rd_idx = 0;
    int xf_tot = 0, rd_tot = 0, done_tot = 0;
    int first_xf_cyc = -1, done_cyc = -1;
    bit prev_hold = 0;
    logic [CW-1:0] prev_a, prev_b;

    dot_operand_streamer #(
        .element_width(EW), .no_of_units(N), .addr_width(AW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .total(total),
        .base_a(base_a), .base_b(base_b),
        .mem_a_rd_en(mem_a_rd_en), .mem_b_rd_en(mem_b_rd_en),
        .mem_a_addr(mem_a_addr), .mem_b_addr(mem_b_addr),
        .mem_a_rdata(mem_a_rdata), .mem_b_rdata(mem_b_rdata),
        .first_row_plus_additional(first_row), .vector2(vector2),
        .outsider_read_now(valid), .consumer_ready(consumer_ready),
        .busy(busy), .done(done)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] elem(input logic [15:0] addr,
                                         input int lane,
                                         input logic [31:0] off);
        return off + {16'd0, addr} * 32'd8 + 32'(lane);
    endfunction

    function automatic logic [CW-1:0] mk_chunk(input logic [15:0] addr,
                                               input logic [31:0] off);
        logic [CW-1:0] r;
        for (int i = 0; i < N; i++) r[i*EW +: EW] = elem(addr, i, off);
        return r;
    endfunction

    // Element j of a vector lives at chunk base+j/N, lane j%N.
    function automatic logic [CW-1:0] exp_chunk(input logic [15:0] base,
                                                input int idx, input int tot,
                                                input logic [31:0] off);
        logic [CW-1:0] r;
        for (int i = 0; i < N; i++) begin
            int j;
            j = idx * N + i;
            if (j < tot) r[i*EW +: EW] = elem(base + 16'(j / N), j % N, off);
            else         r[i*EW +: EW] = '0;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_a_rd_en) mem_a_rdata <= mk_chunk(mem_a_addr, 32'd0);
        if (mem_b_rd_en) mem_b_rdata <= mk_chunk(mem_b_addr, 32'd100);
    end

    task automatic check(input bit ok, input string nm,
                         input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_hold = 0;
                xf_idx = 0;
                rd_idx = 0;
            end else begin
                if (run_id != seen_id) begin
                    seen_id = run_id;
                    xf_idx = 0;
                    rd_idx = 0;
                    first_xf_cyc = -1;
                end
                if (!busy) check(valid == 1'b0, "valid_when_idle", valid, 0);
                if (prev_hold) begin
                    check(valid && first_row == prev_a, "hold_a", first_row, prev_a);
                    check(valid && vector2 == prev_b, "hold_b", vector2, prev_b);
                end
                check(mem_a_rd_en == mem_b_rd_en, "rd_en_pair", mem_b_rd_en, mem_a_rd_en);
                if (mem_a_rd_en) begin
                    check(mem_a_addr == cur_ba + 16'(rd_idx), "addr_a",
                          mem_a_addr, cur_ba + 16'(rd_idx));
                    check(mem_b_addr == cur_bb + 16'(rd_idx), "addr_b",
                          mem_b_addr, cur_bb + 16'(rd_idx));
                    rd_idx++;
                    rd_tot++;
                end
                if (valid && consumer_ready) begin
                    logic [CW-1:0] ea, eb;
                    ea = exp_chunk(cur_ba, xf_idx, cur_total, 32'd0);
                    eb = exp_chunk(cur_bb, xf_idx, cur_total, 32'd100);
                    check(first_row == ea, "chunk_a", first_row, ea);
                    check(vector2 == eb, "chunk_b", vector2, eb);
                    if (xf_idx == 0) first_xf_cyc = cyc;
                    xf_idx++;
                    xf_tot++;
                end
                if (mem_a_rd_en)
                    check(rd_idx - xf_idx <= 2, "outstanding", rd_idx - xf_idx, 2);
                if (done) begin
                    done_tot++;
                    done_cyc = cyc;
                end
                prev_hold = valid && !consumer_ready;
                prev_a = first_row;
                prev_b = vector2;
            end
        end
    endtask

    function automatic logic ready_for(input int mode, input int edge_n, input int t0);
        if (mode == 1) return !(edge_n >= t0 + 3 && edge_n <= t0 + 6);
        if (mode == 2) return ($urandom_range(0, 3) != 0);
        return 1'b1;
    endfunction

    task automatic run_stream(input vec_t v);
        int t0, sx, sr, sd;
        bit got;
        @(posedge clk); #1;
        total = 32'(v.total);
        base_a = v.ba;
        base_b = v.bb;
        cur_total = v.total;
        cur_ba = v.ba;
        cur_bb = v.bb;
        start = 1'b1;
        t0 = cyc + 1;
        consumer_ready = ready_for(v.mode, cyc + 1, t0);
        sx = xf_tot;
        sr = rd_tot;
        sd = done_tot;
        run_id++;
        got = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            start = (v.poke != 0) && (cyc + 1 == t0 + v.poke);
            if (start) begin
                total = 32'd8;
                base_a = 16'h7000;
                base_b = 16'h7100;
            end
            consumer_ready = ready_for(v.mode, cyc + 1, t0);
            if (done_tot != sd) begin
                got = 1;
                break;
            end
        end
        start = 1'b0;
        check(got, "done_timeout", got, 1);
        consumer_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check(done_tot - sd == 1, "done_count", done_tot - sd, 1);
        check(xf_tot - sx == v.exp_chunks, "chunk_count", xf_tot - sx, v.exp_chunks);
        check(rd_tot - sr == v.exp_chunks, "read_count", rd_tot - sr, v.exp_chunks);
        if (v.exp_first >= 0)
            check(first_xf_cyc - t0 == v.exp_first, "first_latency",
                  first_xf_cyc - t0, v.exp_first);
        if (v.exp_done >= 0)
            check(done_cyc - t0 == v.exp_done, "done_latency",
                  done_cyc - t0, v.exp_done);
    endtask

    vec_t tbl[9];

    initial begin
        vec_t v;
        int sd;
        bit got;
        reset = 1'b1;
        start = 1'b0;
        total = '0;
        base_a = '0;
        base_b = '0;
        consumer_ready = 1'b1;
        cur_total = 0;
        cur_ba = '0;
        cur_bb = '0;
        fork
            monitor();
        join_none

        tbl[0] = '{16, 16'h0000, 16'h0000, 0, 0, 2, 2, 4};
        tbl[1] = '{13, 16'h0000, 16'h0000, 0, 0, 2, 2, 4};
        tbl[2] = '{0, 16'h0005, 16'h0009, 0, 0, 0, -1, 0};
        tbl[3] = '{32, 16'h0000, 16'h0000, 1, 0, 4, 6, -1};
        tbl[4] = '{24, 16'h0020, 16'h0040, 0, 2, 3, 2, 5};
        tbl[5] = '{16, 16'h0003, 16'h0007, 0, 5, 2, 2, 4};
        tbl[6] = '{9, 16'hFFFF, 16'h0001, 0, 0, 2, 2, 4};
        tbl[7] = '{1, 16'h0011, 16'h0022, 0, 0, 1, 2, 3};
        tbl[8] = '{40, 16'h0100, 16'h0200, 2, 0, 5, -1, -1};

        repeat (3) @(posedge clk);
        #1;
        check({mem_a_rd_en, mem_b_rd_en, valid, busy, done} == 5'b0,
              "reset_ctrl", {mem_a_rd_en, mem_b_rd_en, valid, busy, done}, 0);
        check(first_row == '0 && vector2 == '0, "reset_data", first_row | vector2, 0);
        check(mem_a_addr == '0 && mem_b_addr == '0, "reset_addr",
              mem_a_addr | mem_b_addr, 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        for (int t = 0; t < 9; t++) run_stream(tbl[t]);

        for (int t = 0; t < 12; t++) begin
            int c;
            v.total = int'($urandom_range(0, 40));
            v.ba = 16'($urandom);
            v.bb = 16'($urandom);
            v.mode = int'($urandom_range(0, 2));
            v.poke = 0;
            c = (v.total + N - 1) / N;
            v.exp_chunks = c;
            v.exp_first = (v.mode == 0 && c > 0) ? 2 : -1;
            v.exp_done = (v.mode != 0) ? -1 : ((c == 0) ? 0 : c + 2);
            run_stream(v);
        end

        // Asynchronous reset after chunk 1 of 4, then a clean restart.
        @(posedge clk); #1;
        total = 32'd32;
        base_a = 16'h0010;
        base_b = 16'h0030;
        cur_total = 32;
        cur_ba = 16'h0010;
        cur_bb = 16'h0030;
        start = 1'b1;
        consumer_ready = 1'b1;
        run_id++;
        sd = done_tot;
        got = 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (xf_idx >= 2) begin
                got = 1;
                break;
            end
        end
        check(got, "reset_wait_timeout", got, 1);
        #2 reset = 1'b1;
        #1;
        check({mem_a_rd_en, valid, busy, done} == 4'b0, "midreset_ctrl",
              {mem_a_rd_en, valid, busy, done}, 0);
        check(first_row == '0 && vector2 == '0, "midreset_data",
              first_row | vector2, 0);
        @(posedge clk); #1;
        check(mem_a_rd_en == 1'b0 && busy == 1'b0, "midreset_hold",
              {mem_a_rd_en, busy}, 0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check(done_tot == sd, "midreset_no_done", done_tot - sd, 0);
        v = '{8, 16'h0010, 16'h0030, 0, 0, 1, 2, 3};
        run_stream(v);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dot_operand_streamer.md
# dot_operand_streamer

Transmit side of the chunked dot-product operand interface. On `start`, it reads two vectors from two chunk-wide memory read ports, one `no_of_units`-element chunk per address. It presents the operand pairs on `first_row_plus_additional` / `vector2`, qualified by `outsider_read_now`. It sits between the vector memories and the vector×vector dot-product control block, zero-pads the final partial chunk, and signals `done` when every chunk has been accepted.

## Interface
- `element_width`, 32: bits per element
- `no_of_units`, 8: elements per chunk (lanes)
- `addr_width`, 16: chunk address width
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle request; sampled only in IDLE
- `total`  in  32  vector length in elements; latched at start
- `base_a`, `base_b`  in  addr_width  chunk address of element 0 of each vector
- `mem_a_rd_en`, `mem_b_rd_en`  out  1  read strobes, always asserted together
- `mem_a_addr`, `mem_b_addr`  out  addr_width  chunk addresses
- `mem_a_rdata`, `mem_b_rdata`  in  element_width*no_of_units  read data, valid exactly 1 cycle after rd_en
- `first_row_plus_additional`  out  element_width*no_of_units  operand A chunk
- `vector2`  out  element_width*no_of_units  operand B chunk
- `outsider_read_now`  out  1  chunk valid
- `consumer_ready`  in  1  consumer accepts the chunk this cycle
- `busy`  out  1  high from the cycle after start until done
- `done`  out  1  one-cycle pulse

## Operation
- **Chunk count:** `C = ceil(total/no_of_units)`, computed at start. The last chunk holds `r = total mod no_of_units` valid lanes; `r = 0` means the chunk is full.
- **Lane mapping:** lane i occupies bits `[i*element_width +: element_width]` and carries element `chunk*no_of_units + i`.
- **Zero padding:** in the last chunk, lanes ≥ r are forced to 0 on both operands.
- **FSM states:** IDLE, FETCH, DRAIN, DONE.
  - IDLE → FETCH on `start` when `total > 0`.
  - IDLE → DONE on `start` when `total == 0`; no reads are issued.
  - FETCH issues reads at `base + k` for k = 0..C-1.
  - FETCH → DRAIN after read C-1 is issued.
  - DRAIN → DONE when chunk C-1 is accepted.
  - DONE → IDLE unconditionally.
- **Buffering:** a 2-entry chunk FIFO sits on the output.
  - A read is issued only when FIFO occupancy plus reads in flight is less than 2. This gives full throughput with no overflow under backpressure.
- **Transfer rule:** a chunk transfers on a cycle with `outsider_read_now && consumer_ready`. While `outsider_read_now` is high and `consumer_ready` is low, the outputs hold stable.
- **Start handling:** `start` is ignored while `busy`. `total`, `base_a` and `base_b` are latched at start, so later changes have no effect.
- **Reset values:** all outputs 0, FSM in IDLE, FIFO empty. Reset mid-stream discards all in-flight data with no `done` pulse.

## Timing
- Start sampled at edge T. First rd_en is high in the cycle after T.
- Read data is captured into the FIFO one cycle after the read. `outsider_read_now` rises the cycle after capture (the FIFO head is registered).
- Latency from `start` to first valid chunk: 3 cycles.
- With `consumer_ready` held high, one chunk transfers per cycle. Chunk C-1 transfers at T+2+C.
- `done` pulses the cycle after the last transfer. `busy` falls in the same cycle `done` pulses.
- `total == 0`: `done` pulses 1 cycle after start.
- `outsider_read_now` must never be high in IDLE or DONE.

## Structure
- **Shared package:** `element_width` and `no_of_units` defaults, the FSM state encoding, and the chunk-width localparam. The dot-product control block uses the same package.
- **Sub-module:** `two_entry_chunk_fifo`, 2-entry, registered head, occupancy output. The FSM, address counters, chunk counter and pad mask stay in the top level.

## Test plan
- **Full chunks:** `total=16`, N=8, memories preloaded with A[i]=i and B[i]=100+i, `consumer_ready=1`. Expect 2 chunks: lanes 0..7 then 8..15, on consecutive cycles starting T+3; `done` at T+5.
- **Partial last chunk:** `total=13`. The second chunk carries elements 8..12 in lanes 0..4; lanes 5..7 are 0 on both outputs. Exactly 2 reads are issued.
- **Empty vector:** `total=0`. No rd_en ever; `done` pulses at T+1; `outsider_read_now` stays 0.
- **Backpressure:** `total=32`, `consumer_ready` low for cycles T+3..T+6. Outputs hold chunk 0 stable, at most 2 reads are outstanding, and no chunk is lost or duplicated. All 4 chunks arrive in order.
- **Start while busy:** a second `start` with `total=8` arrives mid-stream. It is ignored: the original C chunks only, one `done`.
- **Reset mid-stream:** reset asserted asynchronously after chunk 1 of 4. All outputs go to 0 immediately and `busy` clears. A fresh `start` with `total=8` then runs cleanly from `base_a`.
